// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding and image-format constants.
// Imported by the loader top and its byte assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Host byte channel plus instruction-memory write port.
// master: host/memory side, slave: the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs 4 bytes little-endian into a word; word_valid pulses one cycle.
// Ports: clk, rst, clear, byte_en, in_byte -> word, word_valid, last_byte.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [BCNT_W-1:0] cnt;
  logic [31:0]       sr;
  logic [31:0]       sr_next;

  // New bytes enter at the top so the first byte lands in [7:0].
  assign sr_next   = {in_byte, sr[31:8]};
  assign last_byte = byte_en &&
                     (cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        sr  <= sr_next;
        cnt <= cnt + 1'b1;
        // word is held between completions so the
        // write data stays stable while imem_we is low
        if (last_byte) begin
          word       <= sr_next;
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed program image from a byte stream into imem.
// Ports: clk, rst, start, bus (slave), cpu_hold, done, error.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        xr;
  logic              accept;
  logic              restart;
  logic              asm_en;
  logic              last_byte;
  logic              word_valid;
  logic [31:0]       word;

  assign bus.in_ready = (state == HDR0) ||
                        (state == HDR1) ||
                        (state == DATA) ||
                        (state == CSUM);

  assign accept   = bus.in_valid && bus.in_ready;
  assign restart  = start &&
                    ((state == DONE) || (state == ERR));
  assign asm_en   = accept && (state == DATA);
  assign cnt_next = CNT_W'({bus.in_data, count[7:0]});

  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = word;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_en    (asm_en),
    .in_byte    (bus.in_data),
    .word       (word),
    .word_valid (word_valid),
    .last_byte  (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR0;
      count    <= '0;
      widx     <= '0;
      addr     <= '0;
      xr       <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      unique case (state)
        HDR0: begin
          if (accept) begin
            count[7:0] <= bus.in_data;
            xr         <= xr ^ bus.in_data;
            state      <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            count <= cnt_next;
            xr    <= xr ^ bus.in_data;
            if (cnt_next > CNT_W'(DEPTH)) begin
              state <= ERR;
              error <= 1'b1;
            end else if (cnt_next == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            xr <= xr ^ bus.in_data;
          end
          if (last_byte) begin
            addr <= widx;
            // index stops at the last word so a full-depth
            // image never wraps it
            if (CNT_W'(widx) == count - 1'b1) begin
              state <= CSUM;
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.in_data == xr) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state    <= HDR0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            count    <= '0;
            widx     <= '0;
            xr       <= '0;
          end
        end
        ERR: begin
          if (start) begin
            state <= HDR0;
            error <= 1'b0;
            count <= '0;
            widx  <= '0;
            xr    <= '0;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule
